// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states, counter sizing.
package hilo_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hilo_muldiv_iter_core.sv
// Iterative magnitude datapath: radix-2 shift-add multiply and restoring divide, one bit per step.
// Operands are latched as magnitudes; sign bits are handed back to the caller for the final fix-up.
module muldiv_iter_core
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk,
    input  logic             clr,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_is_div,
    output logic             o_neg_lo,
    output logic             o_neg_hi,
    output logic             o_dz,
    output logic             o_last
);

    localparam int CW = clog2(WIDTH);

    logic [WIDTH-1:0] r_hi, r_lo, r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div, r_neg_lo, r_neg_hi, r_dz;

    logic             w_signed, w_div, w_ge, w_last;
    logic [WIDTH-1:0] w_a_mag, w_b_mag, w_rem_sub;
    logic [WIDTH:0]   w_madd, w_rem_sh;

    assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
    assign w_div    = (i_op == OP_DIV)  || (i_op == OP_DIVU);
    assign w_a_mag  = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_b_mag  = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;

    // Multiply: r_lo holds the shrinking multiplier, product grows in {r_hi, r_lo}.
    assign w_madd    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    // Divide: r_hi is the partial remainder, quotient bits shift into r_lo behind the dividend.
    assign w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
    assign w_ge      = w_rem_sh >= {1'b0, r_b};
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_b;
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_dz     <= 1'b0;
        end else if (i_load) begin
            r_hi     <= '0;
            r_lo     <= w_a_mag;
            r_b      <= w_b_mag;
            r_cnt    <= '0;
            r_is_div <= w_div;
            r_neg_lo <= w_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_hi <= w_signed && i_a[WIDTH-1];
            r_dz     <= w_div && (i_b == '0);
        end else if (i_step) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (r_is_div) begin
                r_hi <= w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], w_ge};
            end else begin
                r_hi <= w_madd[WIDTH:1];
                r_lo <= {w_madd[0], r_lo[WIDTH-1:1]};
            end
        end
    end

    assign o_hi     = r_hi;
    assign o_lo     = r_lo;
    assign o_is_div = r_is_div;
    assign o_neg_lo = r_neg_lo;
    assign o_neg_hi = r_neg_hi;
    assign o_dz     = r_dz;
    assign o_last   = w_last;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with iterative MULT/MULTU/DIV/DIVU; result WIDTH+1 edges after start, done pulses after.
// Optional HILO_ACCUM_EN adds an acc input turning multiplies into accumulate-into-{HI,LO}.
module hilo_muldiv
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             WE_HI,
    input  logic             WE_LO,
    input  logic [WIDTH-1:0] HI_in,
    input  logic [WIDTH-1:0] LO_in,
`ifdef HILO_ACCUM_EN
    input  logic             acc,
`endif
    output logic [WIDTH-1:0] HI_out,
    output logic [WIDTH-1:0] LO_out,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    state_t r_state, w_next;
    logic   w_load, w_step, w_fix, w_idle;

    logic [WIDTH-1:0]   w_core_hi, w_core_lo, w_quo, w_rem;
    logic               w_is_div, w_neg_lo, w_neg_hi, w_dz, w_last;
    logic [2*WIDTH-1:0] w_prod, w_mres;

    logic [WIDTH-1:0] r_hi, r_lo;
    logic             r_done, r_dz;

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .clr      (clr),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_op     (op),
        .i_a      (a),
        .i_b      (b),
        .o_hi     (w_core_hi),
        .o_lo     (w_core_lo),
        .o_is_div (w_is_div),
        .o_neg_lo (w_neg_lo),
        .o_neg_hi (w_neg_hi),
        .o_dz     (w_dz),
        .o_last   (w_last)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_next = CALC;
            CALC:    if (w_last) w_next = FIX;
            FIX:                 w_next = IDLE;
            default:             w_next = IDLE;
        endcase
    end

    always_comb begin
        w_idle = 1'b0;
        w_load = 1'b0;
        w_step = 1'b0;
        w_fix  = 1'b0;
        case (r_state)
            IDLE: begin
                w_idle = 1'b1;
                w_load = start;
            end
            CALC:    w_step = 1'b1;
            FIX:     w_fix  = 1'b1;
            default: w_idle = 1'b1;
        endcase
    end

    // Sign fix-up: products negate as one 2*WIDTH value; remainder takes the dividend's sign.
    assign w_prod = w_neg_lo ? -{w_core_hi, w_core_lo} : {w_core_hi, w_core_lo};
    assign w_quo  = w_dz ? '1 : (w_neg_lo ? -w_core_lo : w_core_lo);
    assign w_rem  = w_neg_hi ? -w_core_hi : w_core_hi;

`ifdef HILO_ACCUM_EN
    logic r_acc;
    always_ff @(posedge clk or posedge clr) begin
        if (clr)         r_acc <= 1'b0;
        else if (w_load) r_acc <= acc;
    end
    assign w_mres = r_acc ? ({r_hi, r_lo} + w_prod) : w_prod;
`else
    assign w_mres = w_prod;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_fix) begin
            if (w_is_div) begin
                r_hi <= w_rem;
                r_lo <= w_quo;
            end else begin
                {r_hi, r_lo} <= w_mres;
            end
        end else if (w_idle) begin
            if (WE_HI) r_hi <= HI_in;
            if (WE_LO) r_lo <= LO_in;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            r_done <= w_fix;
            r_dz   <= w_fix && w_dz;
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dz;
    assign HI_out      = r_hi;
    assign LO_out      = r_lo;

endmodule
